hamming_secded_core: RTL
========================

Name: hamming_secded_core

Overview:
- Clocked, parametrised successor to the network core's Hamming encode/decode endpoint.
- TX path: takes {data, address} from a data generator, adds SECDED (extended Hamming) check bits, and sends the packet towards the router.
- RX path: takes a packet from the router, corrects single-bit errors, detects double-bit errors, and delivers {data, address} to the data bucket with error flags and saturating error counters.
- Both paths use valid/ready handshakes and are independent, so they may operate in the same cycle.

Parameters:
- DATA_W, 4: payload data bits per packet (≥2).
- ADDR_W, 4: address/IP field width, carried unprotected.
- COUNT_W, 8: width of each saturating error counter.
- Derived localparam R: smallest integer with 2^R ≥ DATA_W+R+1.
- Derived localparam CW_W = DATA_W+R+1 (codeword width). PKT_W = CW_W+ADDR_W.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- tx_in_valid  in  1  generator word valid
- tx_in_ready  out  1  core can accept generator word
- tx_in_data  in  DATA_W+ADDR_W  {data, addr}, addr in LSBs
- tx_out_valid  out  1  encoded packet valid
- tx_out_ready  in  1  router accepts packet
- tx_out_pkt  out  PKT_W  {codeword, addr}, addr in LSBs
- rx_in_valid  in  1  router packet valid
- rx_in_ready  out  1  core can accept packet
- rx_in_pkt  in  PKT_W  {codeword, addr}
- rx_out_valid  out  1  decoded word valid
- rx_out_ready  in  1  bucket accepts word
- rx_out_data  out  DATA_W+ADDR_W  {corrected data, addr}
- rx_out_sgl  out  1  word had a corrected single-bit error
- rx_out_dbl  out  1  uncorrectable error; data passed uncorrected
- cnt_clr  in  1  synchronous clear of both counters
- sgl_cnt  out  COUNT_W  corrected-error count
- dbl_cnt  out  COUNT_W  uncorrectable-error count

Behaviour:
- Codeword layout:
  - Bit i-1 holds Hamming position i, for i = 1..CW_W-1.
  - Power-of-two positions hold parity; remaining positions hold data[0..DATA_W-1] in ascending order.
  - Position 2^k parity is the XOR of all positions whose index has bit k set.
  - The MSB (bit CW_W-1) is the overall parity, chosen so the whole codeword has even parity.
- Reset: all valid outputs 0, flags 0, counters 0, data/pkt registers 0. Reset asserted mid-transfer discards in-flight words with no partial output.
- A transfer happens on any edge where valid && ready. Valid must not depend on ready. Once a valid is raised, its payload is held stable until accepted.
- TX path:
  - Single output register, latency 1 cycle.
  - tx_in_ready = !tx_out_valid || tx_out_ready, giving full throughput of 1 packet/cycle under no backpressure.
- RX path:
  - Two-stage pipeline. S1 registers the packet plus syndrome S (R bits) and overall parity P. S2 registers the corrected output and flags.
  - Latency is 2 cycles from the accept edge to rx_out_valid.
  - Each stage advances when its downstream is empty or being drained, so bubbles collapse.
  - rx_in_ready = !s1_valid || s1_advances.
  - Throughput is 1 packet/cycle.
- Decode rules:
  - S=0, P=0: clean, both flags 0.
  - S=0, P=1: overall parity bit flipped; data unchanged; sgl=1.
  - S≠0, P=1, S ≤ CW_W-1: flip bit S-1; sgl=1.
  - S≠0, P=1, S > CW_W-1: dbl=1; no correction.
  - S≠0, P=0: dbl=1; data unchanged.
  - The address field is never checked or altered.
- Counters:
  - Increment on the rx_out accept handshake (not on S2 load), selecting sgl_cnt or dbl_cnt by the flag.
  - Saturate at all-ones with no wrap.
  - cnt_clr has priority over a same-cycle increment: the result is 0.

Test Plan:
- DATA_W=4, ADDR_W=4. tx_in_data={4'hB,4'h3}, tx_out_ready=1 → one cycle later tx_out_pkt=12'h553 (cw 8'h55), tx_out_valid=1 for exactly one cycle.
- rx_in_pkt=12'h553 → 2 cycles later rx_out_data=8'hB3, sgl=0, dbl=0, both counters 0. Repeat with 12'h453 (bit4 flipped) → data 8'hB3, sgl=1, sgl_cnt=1. Repeat with 12'hD53 (MSB flipped) → data 8'hB3, sgl=1, sgl_cnt=2.
- rx_in_pkt=12'h563 (bits 0 and 1 flipped) → rx_out_dbl=1, rx_out_data=8'hB3 (data positions untouched), dbl_cnt=1, sgl_cnt unchanged.
- Backpressure: stream 4 packets back-to-back with rx_out_ready low for 5 cycles → rx_in_ready drops after 2 accepts. After release, all 4 words emerge in order, none lost or duplicated, then 1/cycle.
- COUNT_W=2: inject 5 single errors → sgl_cnt saturates at 3. Assert cnt_clr in the same cycle as a 6th error handshake → sgl_cnt=0.
- Deassert rst_n asynchronously (mid-clock) while both pipelines hold data → all valids, flags and counters 0 immediately. No output appears after rst_n rises until new input is accepted.

Source files
------------

// File: rtl/hamming_secded_core.sv
// SECDED (extended Hamming) encode/decode endpoint for the network core.
//
// TX path: {data, addr} from the generator is encoded into {codeword, addr} and held in a
// single output register (1-cycle latency, full throughput).
// RX path: {codeword, addr} from the router passes through a two-stage pipeline. S1 holds the
// packet with its syndrome and overall parity; S2 holds the corrected {data, addr} and flags.
// Single-bit errors are corrected, double-bit errors are flagged and passed through uncorrected.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   tx_in_valid/ready/data             generator word {data, addr}
//   tx_out_valid/ready/pkt             encoded packet {codeword, addr}
//   rx_in_valid/ready/pkt              received packet {codeword, addr}
//   rx_out_valid/ready/data/sgl/dbl    decoded word and error flags
//   cnt_clr                            synchronous clear of both error counters
//   sgl_cnt, dbl_cnt                   saturating corrected/uncorrectable error counters
//
// Codeword: bit i-1 holds Hamming position i (1..CW_W-1); powers of two are parity, the rest
// carry data[0..DATA_W-1] ascending. The MSB makes the whole codeword even parity.
module hamming_secded_core #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned COUNT_W = 8,
  // Smallest R with 2^R >= DATA_W + R + 1 (valid for DATA_W up to 247).
  localparam int unsigned R = (DATA_W <= 1)  ? 2 :
                              (DATA_W <= 4)  ? 3 :
                              (DATA_W <= 11) ? 4 :
                              (DATA_W <= 26) ? 5 :
                              (DATA_W <= 57) ? 6 :
                              (DATA_W <= 120) ? 7 : 8,
  localparam int unsigned CW_W  = DATA_W + R + 1,
  localparam int unsigned PKT_W = CW_W + ADDR_W,
  localparam int unsigned IN_W  = DATA_W + ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  // TX path
  input  logic               tx_in_valid,
  output logic               tx_in_ready,
  input  logic [IN_W-1:0]    tx_in_data,
  output logic               tx_out_valid,
  input  logic               tx_out_ready,
  output logic [PKT_W-1:0]   tx_out_pkt,
  // RX path
  input  logic               rx_in_valid,
  output logic               rx_in_ready,
  input  logic [PKT_W-1:0]   rx_in_pkt,
  output logic               rx_out_valid,
  input  logic               rx_out_ready,
  output logic [IN_W-1:0]    rx_out_data,
  output logic               rx_out_sgl,
  output logic               rx_out_dbl,
  // Error counters
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] sgl_cnt,
  output logic [COUNT_W-1:0] dbl_cnt
);

  // ---------------------------------------------------------------------------------------------
  // Codeword helpers
  // ---------------------------------------------------------------------------------------------
  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    int unsigned     j;
    logic            p;
    cw = '0;
    j  = 0;
    for (int unsigned i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i-1] = d[j];
        j++;
      end
    end
    // Parity positions are still zero here, so they do not disturb each other's sums.
    for (int unsigned k = 0; k < R; k++) begin
      p = 1'b0;
      for (int unsigned i = 1; i < CW_W; i++) begin
        if (((i >> k) & 1) != 0) p ^= cw[i-1];
      end
      cw[(1 << k) - 1] = p;
    end
    cw[CW_W-1] = ^cw[CW_W-2:0];
    return cw;
  endfunction

  // Syndrome as the XOR of the positions of all set bits; zero for a valid codeword.
  function automatic logic [R-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [R-1:0] s;
    s = '0;
    for (int unsigned i = 1; i < CW_W; i++) begin
      if (cw[i-1]) s ^= i[R-1:0];
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int unsigned       j;
    d = '0;
    j = 0;
    for (int unsigned i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = cw[i-1];
        j++;
      end
    end
    return d;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // TX path: one output register
  // ---------------------------------------------------------------------------------------------
  logic             tx_valid_q, tx_valid_d;
  logic [PKT_W-1:0] tx_pkt_q, tx_pkt_d;
  logic             tx_accept;

  assign tx_in_ready = !tx_valid_q || tx_out_ready;
  assign tx_accept   = tx_in_valid && tx_in_ready;

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_pkt_d   = tx_pkt_q;
    if (tx_accept) begin
      tx_valid_d = 1'b1;
      tx_pkt_d   = {encode(tx_in_data[IN_W-1:ADDR_W]), tx_in_data[ADDR_W-1:0]};
    end else if (tx_out_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_pkt_q   <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_pkt_q   <= tx_pkt_d;
    end
  end

  assign tx_out_valid = tx_valid_q;
  assign tx_out_pkt   = tx_pkt_q;

  // ---------------------------------------------------------------------------------------------
  // RX path: S1 (packet + syndrome + parity), S2 (corrected word + flags)
  // ---------------------------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [PKT_W-1:0] s1_pkt_q, s1_pkt_d;
  logic [R-1:0]     s1_syn_q, s1_syn_d;
  logic             s1_par_q, s1_par_d;

  logic             s2_valid_q, s2_valid_d;
  logic [IN_W-1:0]  s2_data_q, s2_data_d;
  logic             s2_sgl_q, s2_sgl_d;
  logic             s2_dbl_q, s2_dbl_d;

  logic             s2_load, rx_accept, rx_out_fire;
  logic [CW_W-1:0]  s1_cw, dec_cw;
  logic             dec_sgl, dec_dbl;

  assign s2_load     = s1_valid_q && (!s2_valid_q || rx_out_ready);
  assign rx_in_ready = !s1_valid_q || s2_load;
  assign rx_accept   = rx_in_valid && rx_in_ready;
  assign rx_out_fire = s2_valid_q && rx_out_ready;
  assign s1_cw       = s1_pkt_q[PKT_W-1:ADDR_W];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pkt_d   = s1_pkt_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (rx_accept) begin
      s1_valid_d = 1'b1;
      s1_pkt_d   = rx_in_pkt;
      s1_syn_d   = syndrome(rx_in_pkt[PKT_W-1:ADDR_W]);
      s1_par_d   = ^rx_in_pkt[PKT_W-1:ADDR_W];
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Correction decision from the S1 syndrome (S) and overall parity (P).
  always_comb begin
    dec_cw  = s1_cw;
    dec_sgl = 1'b0;
    dec_dbl = 1'b0;
    if (s1_syn_q == '0) begin
      // Only the overall parity bit can be wrong; data is intact.
      dec_sgl = s1_par_q;
    end else if (!s1_par_q) begin
      dec_dbl = 1'b1;
    end else if (32'(s1_syn_q) >= CW_W) begin
      // Syndrome points outside the codeword: more than one bit must be bad.
      dec_dbl = 1'b1;
    end else begin
      dec_sgl = 1'b1;
      for (int unsigned i = 0; i < CW_W - 1; i++) begin
        if (i + 1 == 32'(s1_syn_q)) dec_cw[i] = ~s1_cw[i];
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sgl_d   = s2_sgl_q;
    s2_dbl_d   = s2_dbl_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = {extract(dec_cw), s1_pkt_q[ADDR_W-1:0]};
      s2_sgl_d   = dec_sgl;
      s2_dbl_d   = dec_dbl;
    end else if (rx_out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pkt_q   <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sgl_q   <= 1'b0;
      s2_dbl_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pkt_q   <= s1_pkt_d;
      s1_syn_q   <= s1_syn_d;
      s1_par_q   <= s1_par_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sgl_q   <= s2_sgl_d;
      s2_dbl_q   <= s2_dbl_d;
    end
  end

  assign rx_out_valid = s2_valid_q;
  assign rx_out_data  = s2_data_q;
  assign rx_out_sgl   = s2_sgl_q;
  assign rx_out_dbl   = s2_dbl_q;

  // ---------------------------------------------------------------------------------------------
  // Saturating error counters, counted when the bucket takes the word
  // ---------------------------------------------------------------------------------------------
  logic [COUNT_W-1:0] sgl_cnt_q, sgl_cnt_d;
  logic [COUNT_W-1:0] dbl_cnt_q, dbl_cnt_d;

  always_comb begin
    sgl_cnt_d = sgl_cnt_q;
    dbl_cnt_d = dbl_cnt_q;
    if (cnt_clr) begin
      sgl_cnt_d = '0;
      dbl_cnt_d = '0;
    end else if (rx_out_fire) begin
      if (s2_sgl_q && (sgl_cnt_q != '1)) sgl_cnt_d = sgl_cnt_q + COUNT_W'(1);
      if (s2_dbl_q && (dbl_cnt_q != '1)) dbl_cnt_d = dbl_cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgl_cnt_q <= '0;
      dbl_cnt_q <= '0;
    end else begin
      sgl_cnt_q <= sgl_cnt_d;
      dbl_cnt_q <= dbl_cnt_d;
    end
  end

  assign sgl_cnt = sgl_cnt_q;
  assign dbl_cnt = dbl_cnt_q;

endmodule
